// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one single-beat stb/ack memory port between two masters.
// m0 is the core's bus master. m1 is a secondary master such as debug or DMA.
// Requests are granted round-robin, and a grant is held until the slave acks.
// A watchdog aborts any transaction the slave leaves unacknowledged for
// TIMEOUT_CYCLES cycles. The aborted master sees a one-cycle err pulse.
//
// Parameters
//   TIMEOUT_CYCLES  cycles a grant may wait for ack before abort (>= 2)
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   mN_stb_i/we_i/adr_i/data_i/sel_i   request side of master N (N = 0, 1)
//   mN_ack_o, mN_err_o                 completion / timeout abort to master N
//   mN_data_o                          slave read data (valid with ack)
//   s_stb_o/we_o/adr_o/data_o/sel_o    request side towards the slave
//   s_ack_i, s_data_i                  slave acknowledge and read data
//   busy_o                             a grant is active
//   owner_o                            granted master, or last granted in idle
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_sel_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_data_i,
  output logic        busy_o,
  output logic        owner_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state_reg, state_next;
  logic          last_reg, last_next;
  logic [CW-1:0] wait_reg, wait_next;

  logic          granted;
  logic          grant_idx;
  logic          sel_stb;
  logic          done_ack;
  logic          timeout;
  logic [1:0]    ack_vec;
  logic [1:0]    err_vec;

  assign granted   = (state_reg != IDLE);
  assign grant_idx = (state_reg == GRANT1);
  assign sel_stb   = grant_idx ? m1_stb_i : m0_stb_i;

  // An ack is honoured only while the owner still requests. A withdrawn
  // request ends silently. Ack beats the watchdog on the final cycle.
  assign done_ack  = granted && sel_stb && s_ack_i;
  assign timeout   = granted && sel_stb && !s_ack_i && (wait_reg == WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;   // m0 wins the first tie
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    unique case (state_reg)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          state_next = last_reg ? GRANT0 : GRANT1;
        end else if (m0_stb_i) begin
          state_next = GRANT0;
        end else if (m1_stb_i) begin
          state_next = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (!sel_stb) begin
          // Protocol violation: drop the grant without touching fairness.
          state_next = IDLE;
        end else if (done_ack || timeout) begin
          state_next = IDLE;
          last_next  = grant_idx;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A grant always returns to IDLE before any new grant. The counter therefore
  // restarts at zero on every grant entry. It stops at WAIT_LAST because the
  // grant ends there, so the counter never wraps.
  always_comb begin
    wait_next = '0;
    if (granted && (state_next != IDLE)) begin
      wait_next = wait_reg + CW'(1);
    end
  end

  always_comb begin
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    ack_vec   = '0;
    err_vec   = '0;
    m0_data_o = '0;
    m1_data_o = '0;
    if (granted) begin
      s_stb_o   = sel_stb && !timeout;
      s_we_o    = grant_idx ? m1_we_i   : m0_we_i;
      s_adr_o   = grant_idx ? m1_adr_i  : m0_adr_i;
      s_data_o  = grant_idx ? m1_data_i : m0_data_i;
      s_sel_o   = grant_idx ? m1_sel_i  : m0_sel_i;
      ack_vec[grant_idx] = done_ack;
      err_vec[grant_idx] = timeout;
      m0_data_o = s_data_i;
      m1_data_o = s_data_i;
    end
  end

  assign m0_ack_o = ack_vec[0];
  assign m1_ack_o = ack_vec[1];
  assign m0_err_o = err_vec[0];
  assign m1_err_o = err_vec[1];
  assign busy_o   = granted;
  assign owner_o  = granted ? grant_idx : last_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_data_i(m0_wdat),
    .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_data_o(m0_rdat),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_data_i(m1_wdat),
    .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_data_o(m1_rdat),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_data_o(s_wdat),
    .s_sel_o(s_sel), .s_ack_i(s_ack), .s_data_i(s_rdat),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who holds the bus, how long it has waited, who went last.
  int m_owner = -1;
  int m_wait  = 0;
  int m_last  = 1;

  initial begin
    logic [1:0]  stb;
    logic        req, to, e_sstb, e_we, e_busy, e_own;
    logic [31:0] e_adr, e_wdat;
    logic [3:0]  e_sel;
    logic [1:0]  e_ack, e_err;
    int n;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_wait = 0; m_last = 1;
      end
      stb = {m1_stb, m0_stb};
      e_sstb = 0; e_we = 0; e_adr = 0; e_wdat = 0; e_sel = 0;
      e_ack = 0; e_err = 0; e_busy = 0; e_own = m_last[0];
      req = 0; to = 0; n = 0;
      if (m_owner >= 0) begin
        n      = m_owner;
        req    = stb[n];
        to     = req && !s_ack && (m_wait == T - 1);
        e_sstb = req && !to;
        e_we   = (n == 1) ? m1_we   : m0_we;
        e_adr  = (n == 1) ? m1_adr  : m0_adr;
        e_wdat = (n == 1) ? m1_wdat : m0_wdat;
        e_sel  = (n == 1) ? m1_sel  : m0_sel;
        e_ack[n] = req && s_ack;
        e_err[n] = to;
        e_busy = 1;
        e_own  = n[0];
      end
      check("cyc_s_stb", s_stb, e_sstb);
      check("cyc_s_we", s_we, e_we);
      check("cyc_s_adr", s_adr, e_adr);
      check("cyc_s_data", s_wdat, e_wdat);
      check("cyc_s_sel", s_sel, e_sel);
      check("cyc_m0_ack", m0_ack, e_ack[0]);
      check("cyc_m1_ack", m1_ack, e_ack[1]);
      check("cyc_m0_err", m0_err, e_err[0]);
      check("cyc_m1_err", m1_err, e_err[1]);
      check("cyc_busy", busy, e_busy);
      check("cyc_owner", owner, e_own);
      if (e_ack[0]) check("cyc_m0_data", m0_rdat, s_rdat);
      if (e_ack[1]) check("cyc_m1_data", m1_rdat, s_rdat);
      if (rst_n) begin
        if (m_owner < 0) begin
          m_wait = 0;
          if (stb == 2'b11) m_owner = 1 - m_last;
          else if (stb[0]) m_owner = 0;
          else if (stb[1]) m_owner = 1;
        end else if (!req) begin
          m_owner = -1;
        end else if (s_ack || to) begin
          m_last = n;
          m_owner = -1;
        end else begin
          m_wait++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0; m0_sel = 0;
    m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0; m1_sel = 0;
    s_ack = 0; s_rdat = 0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 1);
    check("rst_s_stb", s_stb, 0);
    rst_n = 1;
    step();

    // Single read by m0, slave acks 3 cycles after grant
    m0_stb = 1; m0_adr = 32'h100; m0_we = 0; m0_sel = 4'hF;
    step();
    check("t1_s_stb", s_stb, 1);
    check("t1_s_adr", s_adr, 32'h100);
    step(); step(); step();
    s_ack = 1; s_rdat = 32'hDEADBEEF; #1;
    check("t1_m0_ack", m0_ack, 1);
    check("t1_m0_data", m0_rdat, 32'hDEADBEEF);
    check("t1_m1_ack", m1_ack, 0);
    $display("TXN m0 read adr=%h data=%h", m0_adr, m0_rdat);
    step();
    m0_stb = 0; s_ack = 0; #1;
    check("t1_ack_pulse", m0_ack, 0);

    // Simultaneous writes from reset, both held: m0, m1, m0, m1
    rst_n = 0;
    step();
    rst_n = 1;
    m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_wdat = 32'h11;
    m1_stb = 1; m1_we = 1; m1_adr = 32'h20; m1_wdat = 32'h22; m1_sel = 4'hF;
    step();
    for (int k = 0; k < 4; k++) begin
      check("t2_owner", owner, k % 2);
      check("t2_busy", busy, 1);
      check("t2_s_adr", s_adr, (k % 2 == 1) ? 32'h20 : 32'h10);
      step();
      s_ack = 1; #1;
      check("t2_m0_ack", m0_ack, (k % 2 == 0) ? 1 : 0);
      check("t2_m1_ack", m1_ack, (k % 2 == 1) ? 1 : 0);
      $display("TXN tie grant %0d to m%0d adr=%h", k, k % 2, s_adr);
      step();
      s_ack = 0; #1;
      check("t2_bubble", busy, 0);
      check("t2_owner_idle", owner, k % 2);
      if (k == 3) begin
        m0_stb = 0; m1_stb = 0;
      end
      step();
    end

    // m1 write with partial byte select
    m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_wdat = 32'h0000ABCD; m1_adr = 32'h40;
    step();
    check("t3_s_we", s_we, 1);
    check("t3_s_sel", s_sel, 4'b0011);
    check("t3_s_data", s_wdat, 32'h0000ABCD);
    s_ack = 1; #1;
    check("t3_m1_ack", m1_ack, 1);
    check("t3_m0_ack", m0_ack, 0);
    $display("TXN m1 write adr=%h data=%h sel=%b", s_adr, s_wdat, s_sel);
    step();
    m1_stb = 0; s_ack = 0;
    step();

    // Timeout on m0, m1 pending behind it
    m0_stb = 1; m0_we = 0; m0_adr = 32'h200;
    step();
    check("t4_owner", owner, 0);
    m1_stb = 1; m1_we = 0; m1_adr = 32'h300;
    for (int i = 0; i < T - 1; i++) begin
      check("t4_err_early", m0_err, 0);
      step();
    end
    check("t4_m0_err", m0_err, 1);
    check("t4_s_stb", s_stb, 0);
    $display("TXN m0 timeout adr=%h err=%b", m0_adr, m0_err);
    step();
    m0_stb = 0; #1;
    check("t4_idle", busy, 0);
    check("t4_err_pulse", m0_err, 0);
    step();
    check("t4_m1_grant", owner, 1);
    check("t4_m1_adr", s_adr, 32'h300);
    s_ack = 1; #1;
    check("t4_m1_ack", m1_ack, 1);
    $display("TXN m1 read adr=%h after timeout", s_adr);
    step();
    m1_stb = 0; s_ack = 0;
    step();

    // Ack on the final watchdog cycle wins over the abort
    m0_stb = 1; m0_adr = 32'h400;
    step();
    repeat (T - 1) step();
    s_ack = 1; s_rdat = 32'h12345678; #1;
    check("t5_m0_ack", m0_ack, 1);
    check("t5_m0_err", m0_err, 0);
    $display("TXN m0 late ack adr=%h data=%h", m0_adr, m0_rdat);
    step();
    m0_stb = 0; s_ack = 0;
    step();

    // m1 withdraws its request while granted
    m1_stb = 1; m1_adr = 32'h500;
    step();
    check("t6_owner", owner, 1);
    step();
    m1_stb = 0; #1;
    check("t6_s_stb", s_stb, 0);
    check("t6_m1_ack", m1_ack, 0);
    step();
    check("t6_idle", busy, 0);
    check("t6_last_kept", owner, 0);
    $display("TXN m1 withdraw adr=%h", m1_adr);

    // Reset asserted in the middle of an m0 grant
    m0_stb = 1; m0_adr = 32'h600;
    step();
    check("t7_owner", owner, 0);
    m1_stb = 1; m1_adr = 32'h700;
    step();
    #2; rst_n = 0; s_ack = 1; #1;
    check("t7_rst_s_stb", s_stb, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_ack", m0_ack, 0);
    check("t7_rst_owner", owner, 1);
    step();
    s_ack = 0; rst_n = 1;
    step();
    check("t7_m0_first", owner, 0);
    check("t7_s_stb", s_stb, 1);
    s_ack = 1; #1;
    check("t7_m0_ack", m0_ack, 1);
    $display("TXN m0 after reset adr=%h", s_adr);
    step();
    m0_stb = 0; s_ack = 0;
    step();
    check("t7_m1_next", owner, 1);
    s_ack = 1; #1;
    $display("TXN m1 after reset adr=%h", s_adr);
    step();
    m1_stb = 0; s_ack = 0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the core's single-beat memory bus (stb/ack handshake). It shares the memory port between the core's bus master (m0) and a secondary master (m1, debug/DMA). Requests are granted round-robin and held until the slave acks. A watchdog ends any transaction the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, default 256: cycles a granted transaction may wait for ack before being aborted; must be ≥ 2.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mN_stb_i  in  1  request from master N (N = 0, 1)
- mN_we_i  in  1  write enable from master N
- mN_adr_i  in  32  address from master N
- mN_data_i  in  32  write data from master N
- mN_sel_i  in  4  byte select from master N
- mN_ack_o  out  1  transaction complete to master N
- mN_err_o  out  1  transaction aborted by timeout to master N
- mN_data_o  out  32  read data to master N
- s_stb_o  out  1  request to slave
- s_we_o  out  1  write enable to slave
- s_adr_o  out  32  address to slave
- s_data_o  out  32  write data to slave
- s_sel_o  out  4  byte select to slave
- s_ack_i  in  1  slave acknowledge
- s_data_i  in  32  slave read data
- busy_o  out  1  a grant is active
- owner_o  out  1  current or last granted master index

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - only m0_stb_i → GRANT0; only m1_stb_i → GRANT1.
  - Both asserted → grant the master that is not last_grant.
  - last_grant resets to 1, so m0 wins the first tie.
- GRANTn:
  - s_* outputs are combinationally muxed from master n; s_stb_o = mn_stb_i.
  - s_ack_i is routed to mn_ack_o. mn_data_o = s_data_i for both masters; only meaningful with the matching ack.
  - The non-granted master sees ack = err = 0.
- Completion: s_ack_i high in GRANTn → next state IDLE and last_grant ← n.
- Timeout:
  - A wait counter clears on entry to a GRANT state and increments each GRANT cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with s_ack_i low: assert mn_err_o for that one cycle, force s_stb_o low, next state IDLE, last_grant ← n.
  - If ack and timeout coincide, ack wins and no err is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES); it never wraps.
- Master withdraws stb while granted (protocol violation): s_stb_o follows it low. The state returns to IDLE the next cycle, last_grant is unchanged and no ack or err is issued.
- Masters hold stb, adr, we, data and sel stable until they see ack or err, then drop stb for at least one cycle or re-request.
- busy_o = state ≠ IDLE. owner_o = 1 in GRANT1, 0 in GRANT0; in IDLE it shows last_grant.
- In IDLE all s_* outputs are 0.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE, last_grant 1, counter 0.
  - All outputs 0, except owner_o = 1 (it shows last_grant).
  - Reset mid-transaction drops s_stb_o immediately; the pending transaction is lost with no ack or err.
- Grant latency: a request in IDLE at cycle t gives s_stb_o high at t+1.
- ack passes through combinationally in the same cycle as s_ack_i.
- One-cycle IDLE bubble after every ack or err, so back-to-back transactions are spaced at least 2 cycles apart.
- Timeout: with grant at cycle g and no ack, mn_err_o is high at cycle g+TIMEOUT_CYCLES-1 and the state is IDLE at g+TIMEOUT_CYCLES.

## Test plan
- Single read by m0:
  - m0_stb=1, adr 0x100, we=0; slave acks 3 cycles after s_stb_o with s_data_i 0xDEADBEEF.
  - Expect s_adr_o 0x100, m0_ack_o for one cycle with m0_data_o 0xDEADBEEF, m1_ack_o 0.
- Simultaneous requests from reset, both held:
  - m0 write 0x10 and m1 write 0x20 assert in the same cycle; slave acks each after 1 cycle.
  - Expect grant order m0, m1, m0, m1, owner_o toggling, with one IDLE cycle between grants.
- m1 write with sel 4'b0011, data 0x0000ABCD:
  - Expect s_we_o 1, s_sel_o 0011, s_data_o 0x0000ABCD, m1_ack_o pulse.
- Timeout with TIMEOUT_CYCLES = 8:
  - Slave never acks m0.
  - Expect m0_err_o high exactly 7 cycles after grant, s_stb_o low that cycle, then m1 granted if it is pending.
- Ack on the final timeout cycle (cycle 7 with TIMEOUT_CYCLES = 8):
  - Expect m0_ack_o 1 and m0_err_o 0.
- Reset asserted mid-grant:
  - Expect s_stb_o, busy_o and ack outputs 0 immediately, and owner_o 1.
  - After release, a pending m0 request is granted first.
